// File: rtl/multiplier.sv
// rtl/multiplier.sv - 16x16 sequential shift-add multiplier, 16 CALC cycles, registered 32-bit product.
// Define MULTIPLIER_SIGNED_EN for two's-complement operands; the default build is unsigned.
module multiplier (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [31:0] Prod,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] mcand_q, mcand_d;
   logic [15:0] mult_q, mult_d;
   logic [3:0]  idx_q, idx_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] prod_q, prod_d;
   logic        done_q, done_d;
   logic [15:0] a_mag, b_mag;
   logic [31:0] result;

`ifdef MULTIPLIER_SIGNED_EN
   logic        neg_q, neg_d;

   // 0x8000 negates to itself, which read as unsigned is the correct magnitude 32768
   assign a_mag  = A[15] ? (~A + 16'd1) : A;
   assign b_mag  = B[15] ? (~B + 16'd1) : B;
   assign result = neg_q ? (~acc_q + 32'd1) : acc_q;
`else
   assign a_mag  = A;
   assign b_mag  = B;
   assign result = acc_q;
`endif

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q <= S_IDLE;
         mcand_q <= '0;
         mult_q  <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
`ifdef MULTIPLIER_SIGNED_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         mult_q  <= mult_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
`ifdef MULTIPLIER_SIGNED_EN
         neg_q   <= neg_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_CALC;
         S_CALC:  if (idx_q == 4'd15) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mcand_d = mcand_q;
      mult_d  = mult_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
`ifdef MULTIPLIER_SIGNED_EN
      neg_d   = neg_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mcand_d = a_mag;
               mult_d  = b_mag;
               idx_d   = 4'd0;
               acc_d   = 32'd0;
`ifdef MULTIPLIER_SIGNED_EN
               neg_d   = A[15] ^ B[15];
`endif
            end
         end
         S_CALC: begin
            if (mult_q[0]) acc_d = acc_q + (32'(mcand_q) << idx_q);
            mult_d = mult_q >> 1;
            idx_d  = idx_q + 4'd1;
         end
         S_DONE: begin
            prod_d = result;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      busy = (state_q == S_CALC) || (state_q == S_DONE);
   end

   assign Prod = prod_q;
   assign done = done_q;

endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - directed self-checking bench for multiplier (latency, reset, ignored restart).
module tb_multiplier;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic [31:0] Prod;
   logic        busy;
   logic        done;

   int tests = 0;
   int fails = 0;
   logic [31:0] last_exp = 32'd0;

   multiplier dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .start    (start),
      .A        (A),
      .B        (B),
      .Prod     (Prod),
      .busy     (busy),
      .done     (done)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issues one start, then waits for done; latency and busy width are measured in cycles.
   task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
      int cnt;
      int bcnt;
      A = a;
      B = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      A = ~a;
      B = ~b;
      check({tag, "_done_low"}, {31'd0, done}, 32'd0);
      check({tag, "_prod_hold"}, Prod, last_exp);
      cnt = 0;
      bcnt = 0;
      while (!done && cnt < 40) begin
         if (busy) bcnt++;
         tick();
         cnt++;
      end
      check({tag, "_latency"}, cnt, 32'd17);
      check({tag, "_busy_cycles"}, bcnt, 32'd17);
      check({tag, "_prod"}, Prod, exp);
      last_exp = exp;
   endtask

   initial begin
      int dcnt;

      sys_rst_n = 1'b0;
      tick();
      tick();
      check("reset_prod", Prod, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      sys_rst_n = 1'b1;
      tick();

      run_mul("m3x5", 16'd3, 16'd5, 32'h0000000F);
      // back-to-back: the next start lands in the cycle done is high
`ifdef MULTIPLIER_SIGNED_EN
      run_mul("s_m7x6", 16'hFFF9, 16'd6, 32'hFFFFFFD6);
      run_mul("s_min_sq", 16'h8000, 16'h8000, 32'h40000000);
      run_mul("s_m1x1", 16'hFFFF, 16'd1, 32'hFFFFFFFF);
      run_mul("s_m3xm4", 16'hFFFD, 16'hFFFC, 32'h0000000C);
`else
      run_mul("u_max_sq", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
      run_mul("u_zero", 16'h0000, 16'h1234, 32'h00000000);
      run_mul("u_ffffx1", 16'hFFFF, 16'd1, 32'h0000FFFF);
      run_mul("u_8000x2", 16'h8000, 16'd2, 32'h00010000);
`endif
      tick();
      check("done_one_cycle", {31'd0, done}, 32'd0);

      // restart attempt while busy is ignored
      A = 16'd2;
      B = 16'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      dcnt = 0;
      for (int i = 1; i < 30; i++) begin
         if (i == 5) begin
            A = 16'd9;
            B = 16'd9;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         dcnt += int'(done);
         if (done) check("restart_prod", Prod, 32'd6);
         tick();
      end
      start = 1'b0;
      check("restart_single_done", dcnt, 32'd1);
      last_exp = 32'd6;

      // reset mid-CALC aborts without done
      A = 16'd100;
      B = 16'd100;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      sys_rst_n = 1'b0;
      tick();
      sys_rst_n = 1'b1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_prod", Prod, 32'd0);
      dcnt = 0;
      for (int i = 0; i < 25; i++) begin
         dcnt += int'(done);
         tick();
      end
      check("abort_no_done", dcnt, 32'd0);
      last_exp = 32'd0;
      run_mul("post_abort_4x4", 16'd4, 16'd4, 32'd16);

      // reset wins over start in the same cycle
      tick();
      sys_rst_n = 1'b0;
      start = 1'b1;
      tick();
      sys_rst_n = 1'b1;
      start = 1'b0;
      check("rst_prio_busy", {31'd0, busy}, 32'd0);
      check("rst_prio_prod", Prod, 32'd0);
      tick();
      check("rst_prio_idle", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 16 bits and product width at 32 bits.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset: sys_clk and sys_rst_n.
REQ-003 sys_clk  input  1  rising-edge clock for all state.
REQ-004 sys_rst_n  input  1  synchronous active-low reset, sampled on the sys_clk rising edge.
REQ-005 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-006 A  input  16  multiplicand, captured on accepted start.
REQ-007 B  input  16  multiplier, captured on accepted start.
REQ-008 Prod  output  32  registered product; holds its value until the next DONE.
REQ-009 busy  output  1  high in CALC and DONE.
REQ-010 done  output  1  one-cycle pulse; Prod is valid in that cycle.

Function
REQ-011 The FSM SHALL have three states, IDLE, CALC and DONE, with one state register.
REQ-012 In IDLE with start=1 at an edge, the block SHALL capture the operand magnitudes (and signs when enabled), clear the accumulator, set the bit index to 0 and go to CALC.
REQ-013 In CALC, each cycle SHALL do one shift-add step: if mult[0]=1, acc += mcand<<index; then mult >>= 1 and index += 1.
REQ-014 The add SHALL be 32 bits wide, with no truncation of carries.
REQ-015 After the step with index=15, CALC SHALL go to DONE; CALC therefore lasts exactly 16 cycles.
REQ-016 In DONE, the block SHALL load Prod with the final (sign-corrected) result, assert done for exactly one cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed: start is sampled at edge k, and done/Prod are valid in the cycle after edge k+17.
REQ-018 A start seen in CALC or DONE SHALL be ignored; it SHALL NOT corrupt operands or restart the operation.
REQ-019 A or B changing after capture SHALL have no effect on the result in flight.
REQ-020 A zero operand SHALL still take the full 16 cycles and produce Prod=0.
REQ-021 A new start may be accepted in the IDLE cycle right after DONE, giving back-to-back throughput of one result per 18 cycles.

Reset
REQ-022 When sys_rst_n=0 at an edge, the block SHALL force state=IDLE, Prod=0, done=0, busy=0, and clear the accumulator, index and operand registers.
REQ-023 Reset asserted mid-CALC SHALL abort the operation without producing a done pulse; Prod SHALL read 0 afterwards.
REQ-024 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-025 The macro MULTIPLIER_SIGNED_EN SHALL select signed or unsigned operation.
- Defined: A and B are two's complement. Magnitudes are used in CALC, and the product is negated in DONE when A[15]^B[15]=1. The magnitude of 0x8000 is 32768, treated unsigned.
- Undefined: A and B are unsigned; no sign logic is present.

Verification
REQ-026 A=3, B=5, start pulse -> done 18 cycles later, Prod=0x0000000F, busy high for 17 cycles.
REQ-027 Signed build: A=0xFFF9 (-7), B=6 -> Prod=0xFFFFFFD6; A=0x8000, B=0x8000 -> Prod=0x40000000.
REQ-028 Unsigned build: A=0xFFFF, B=0xFFFF -> Prod=0xFFFE0001; A=0, B=0x1234 -> Prod=0 after the full latency.
REQ-029 Start with A=2, B=3, then re-pulse start with A=9, B=9 at cycle 5 -> a single done, Prod=6.
REQ-030 Start A=100, B=100, then drive sys_rst_n=0 at cycle 8 -> no done pulse, Prod=0, busy=0; a following start of 4×4 gives Prod=16.
